// File: rtl/da_coef_loader.sv
// Writer side of the DA coefficient load port: turns a (base, count) command plus a
// valid/ready coefficient stream into one registered CLOAD write per accepted word.
module da_coef_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 19,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] CADDR,
  output logic [DATA_W-1:0] CIN,
  output logic              CLOAD,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              rom_valid
);

  // state | meaning
  // IDLE  | waiting for a command; rejects illegal word counts with load_err
  // LOAD  | accepting words, one CLOAD write per handshake
  // FIN   | final CLOAD on the bus, load_done pulses, rom_valid set
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              cmd_legal;

  assign cmd_legal = (load_count != '0) && (load_count <= DEPTH_C);
  assign s_ready   = (state == LOAD);
  assign busy      = (state == LOAD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      CADDR     <= '0;
      CIN       <= '0;
      CLOAD     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      rom_valid <= 1'b0;
    end else begin
      // Buses are zero whenever no write is presented.
      CLOAD     <= 1'b0;
      CADDR     <= '0;
      CIN       <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            if (cmd_legal) begin
              addr      <= load_base;
              remaining <= load_count;
              rom_valid <= 1'b0;
              state     <= LOAD;
            end else begin
              load_err  <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Abort wins over a same-cycle handshake: that word is dropped.
          if (abort) begin
            state <= IDLE;
          end else if (s_valid) begin
            CLOAD     <= 1'b1;
            CADDR     <= addr;
            CIN       <= s_data;
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              load_done <= 1'b1;
              rom_valid <= 1'b1;
              state     <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_coef_loader.sv
// Bench for da_coef_loader: command vector table plus hand-written abort, reset,
// full-load and busy-ignore sequences; writes are checked against a scoreboard queue.
module tb_da_coef_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_start;
  logic [10:0] load_base;
  logic [11:0] load_count;
  logic        abort;
  logic        s_valid;
  logic [18:0] s_data;
  logic        s_ready;
  logic [10:0] CADDR;
  logic [18:0] CIN;
  logic        CLOAD;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic        rom_valid;

  da_coef_loader #(.ADDR_W(11), .DATA_W(19), .DEPTH(2048)) dut (
    .clk(clk), .resetn(resetn), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .CADDR(CADDR), .CIN(CIN), .CLOAD(CLOAD), .busy(busy),
    .load_done(load_done), .load_err(load_err), .rom_valid(rom_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [18:0] d;
    bit          last;
    int          c;
  } exp_t;

  typedef struct {
    logic [10:0] base;
    logic [11:0] count;
    bit          legal;
    bit          gappy;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [10:0] m_addr;
  logic [11:0] m_rem;
  bit          exp_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every CLOAD must match the oldest expected write, in its expected cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (CLOAD) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", CADDR, CIN);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("caddr", 32'(CADDR), 32'(e.a));
          check("cin", 32'(CIN), 32'(e.d));
          check("cload_cycle", 32'(cyc), 32'(e.c));
          check("done_with_last", 32'(load_done), 32'(e.last));
        end
      end else begin
        check("idle_bus", {12'd0, load_done, CIN}, 32'd0);
        check("idle_addr", 32'(CADDR), 32'd0);
      end
      if (load_done) done_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {CLOAD, s_ready, busy, load_done, load_err, rom_valid}, 32'd0);
    check({name, "_caddr"}, 32'(CADDR), 32'd0);
    check({name, "_cin"}, 32'(CIN), 32'd0);
  endtask

  task automatic start_cmd(input logic [10:0] base, input logic [11:0] cnt, input bit legal);
    load_start = 1'b1;
    load_base  = base;
    load_count = cnt;
    tick();
    load_start = 1'b0;
    check("load_err", 32'(load_err), 32'(!legal));
    check("busy_after_cmd", 32'(busy), 32'(legal));
    check("ready_after_cmd", 32'(s_ready), 32'(legal));
    if (legal) begin
      exp_rv = 1'b0;
      m_addr = base;
      m_rem  = cnt;
    end
    check("rom_valid_cmd", 32'(rom_valid), 32'(exp_rv));
    if (!legal) begin
      tick();
      check("err_one_pulse", {load_err, busy}, 32'd0);
    end
  endtask

  task automatic send_word(input logic [18:0] d, input bit valid);
    s_valid = valid;
    s_data  = d;
    check("s_ready_load", 32'(s_ready), 32'd1);
    if (valid && !abort) begin
      sb.push_back('{a: m_addr, d: d, last: (m_rem == 12'd1), c: cyc + 1});
      m_addr = m_addr + 11'd1;
      m_rem  = m_rem - 12'd1;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic finish_load();
    int d0;
    d0 = done_cnt;
    check("ready_drop", {s_ready, busy}, 32'd0);
    check("rom_valid_set", 32'(rom_valid), 32'd1);
    exp_rv = 1'b1;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_load(input logic [10:0] base, input logic [11:0] cnt,
                          input bit gappy, input bit ramp);
    bit [5:0] pat;
    int       k;
    int       i;
    pat = 6'b110101;
    k = 0;
    i = 0;
    start_cmd(base, cnt, 1'b1);
    while (m_rem != 12'd0) begin
      if (!gappy || pat[k % 6]) begin
        send_word(ramp ? 19'(i - 262144) : 19'($urandom), 1'b1);
        i++;
      end else begin
        send_word(19'($urandom), 1'b0);
      end
      k++;
    end
    finish_load();
  endtask

  initial begin
    int w0;
    int d0;
    vecs[0] = '{base: 11'h010, count: 12'd5,    legal: 1'b1, gappy: 1'b0};
    vecs[1] = '{base: 11'd2046, count: 12'd4,   legal: 1'b1, gappy: 1'b1};
    vecs[2] = '{base: 11'h000, count: 12'd0,    legal: 1'b0, gappy: 1'b0};
    vecs[3] = '{base: 11'h000, count: 12'd2049, legal: 1'b0, gappy: 1'b0};
    vecs[4] = '{base: 11'h3f0, count: 12'd1,    legal: 1'b1, gappy: 1'b0};
    vecs[5] = '{base: 11'h7f8, count: 12'd20,   legal: 1'b1, gappy: 1'b1};

    resetn = 1'b0;
    load_start = 1'b0;
    load_base = '0;
    load_count = '0;
    abort = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    #22;
    check_all_zero("reset");
    resetn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].legal) run_load(vecs[v].base, vecs[v].count, vecs[v].gappy, 1'b0);
      else start_cmd(vecs[v].base, vecs[v].count, 1'b0);
    end

    // Full 2048-word load with s_valid held high.
    w0 = wr_cnt;
    run_load(11'd0, 12'd2048, 1'b0, 1'b1);
    check("full_writes", 32'(wr_cnt - w0), 32'd2048);

    // Abort together with the 5th handshake.
    w0 = wr_cnt;
    d0 = done_cnt;
    tick();
    start_cmd(11'h200, 12'd16, 1'b1);
    for (int i = 0; i < 4; i++) send_word(19'($urandom), 1'b1);
    abort = 1'b1;
    send_word(19'h5a5a5, 1'b1);
    abort = 1'b0;
    check("abort_idle", {s_ready, busy, rom_valid}, 32'd0);
    tick();
    tick();
    check("abort_writes", 32'(wr_cnt - w0), 32'd4);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_sb", 32'(sb.size()), 32'd0);
    check("abort_rv", 32'(rom_valid), 32'd0);
    run_load(11'h080, 12'd3, 1'b0, 1'b0);

    // Second load_start while busy is ignored.
    tick();
    start_cmd(11'h050, 12'd6, 1'b1);
    send_word(19'($urandom), 1'b1);
    send_word(19'($urandom), 1'b1);
    load_start = 1'b1;
    load_base = 11'h600;
    load_count = 12'd3;
    send_word(19'($urandom), 1'b1);
    load_start = 1'b0;
    check("busy_start_no_err", 32'(load_err), 32'd0);
    send_word(19'($urandom), 1'b0);
    check("busy_start_no_err2", 32'(load_err), 32'd0);
    while (m_rem != 12'd0) send_word(19'($urandom), 1'b1);
    finish_load();

    // Asynchronous reset in the middle of a full load.
    start_cmd(11'd0, 12'd2048, 1'b1);
    for (int i = 0; i < 100; i++) send_word(19'($urandom), 1'b1);
    check("pre_reset_cload", 32'(CLOAD), 32'd1);
    #1;
    resetn = 1'b0;
    sb.delete();
    exp_rv = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #3;
    resetn = 1'b1;
    tick();
    check_all_zero("after_reset");
    run_load(11'h700, 12'd8, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
